// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage (ALU, NZCV flags, branch redirect, EX/MEM registers).
// Define EXEC_MUL_EN to add the iterative shift-add multiplier for aluMode 111.
module exec_stage_mc #(
  parameter int WIDTH = 24,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic stall,
  input  logic flush,
  input  logic memWe,
  input  logic regWe,
  input  logic writeRegFromAlu,
  input  logic pcWe,
  input  logic flagsWe,
  input  logic [2:0] aluMode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] pcm4,
  input  logic [WIDTH-1:0] dataToWrite,
  input  logic [REG_ADDR_W-1:0] regToWrite,
  output logic out_valid,
  output logic memWeOut,
  output logic regWeOut,
  output logic writeRegFromAluOut,
  output logic [REG_ADDR_W-1:0] regToWriteOut,
  output logic [WIDTH-1:0] resultOut,
  output logic [WIDTH-1:0] dataToWriteOut,
  output logic [3:0] flags,
  output logic redirect,
  output logic [WIDTH-1:0] newPc
);
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] real_op1, alu_res;
  logic [WIDTH:0] sum, diff;
  logic alu_c, alu_v, accept, is_mul, shift_big;
  logic [3:0] alu_flags;
  assign real_op1 = pcWe ? pcm4 : op1;
  assign sum = {1'b0, real_op1} + {1'b0, op2};
  assign diff = {1'b0, real_op1} - {1'b0, op2};
  assign shift_big = op2 >= WIDTH'(WIDTH);
  assign in_ready = reset && state == IDLE && !stall && !flush;
  assign accept = in_valid && in_ready;
  assign alu_flags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
  always_comb begin
    alu_res = op2;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (aluMode)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (real_op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != real_op1[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_c = !diff[WIDTH];
        alu_v = (real_op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != real_op1[WIDTH-1]);
      end
      3'b010: alu_res = real_op1 & op2;
      3'b011: alu_res = real_op1 | op2;
      3'b100: alu_res = real_op1 ^ op2;
      3'b101: alu_res = shift_big ? '0 : real_op1 << op2;
      3'b110: alu_res = shift_big ? '0 : real_op1 >> op2;
      default: alu_res = op2;
    endcase
  end
`ifdef EXEC_MUL_EN
  logic [2*WIDTH-1:0] acc, mc, step_acc;
  logic [WIDTH-1:0] mp, mul_lo, m_data;
  logic [CNT_W-1:0] cnt;
  logic [REG_ADDR_W-1:0] m_rd;
  logic [3:0] mul_flags;
  logic m_mwe, m_rwe, m_wrfa, m_pwe, m_fwe, mul_done;
  assign is_mul = aluMode == 3'b111;
  assign step_acc = acc + (mp[0] ? mc : '0);
  assign mul_lo = step_acc[WIDTH-1:0];
  assign mul_flags = {mul_lo[WIDTH-1], mul_lo == '0, |step_acc[2*WIDTH-1:WIDTH], 1'b0};
  assign mul_done = state == MUL_BUSY && cnt == CNT_W'(WIDTH - 1) && !stall;
  always_comb state_nxt = flush ? IDLE : (accept && is_mul) ? MUL_BUSY : mul_done ? IDLE : state;
  // Once all multiplier bits are consumed further steps add nothing, so a stalled completion holds the product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      mc <= '0;
      mp <= '0;
      cnt <= '0;
      m_rd <= '0;
      m_data <= '0;
      {m_mwe, m_rwe, m_wrfa, m_pwe, m_fwe} <= '0;
    end else if (accept && is_mul) begin
      acc <= '0;
      mc <= {{WIDTH{1'b0}}, real_op1};
      mp <= op2;
      cnt <= '0;
      m_rd <= regToWrite;
      m_data <= dataToWrite;
      {m_mwe, m_rwe, m_wrfa, m_pwe, m_fwe} <= {memWe, regWe, writeRegFromAlu, pcWe, flagsWe};
    end else if (state == MUL_BUSY) begin
      acc <= step_acc;
      mc <= mc << 1;
      mp <= mp >> 1;
      if (cnt != CNT_W'(WIDTH - 1)) cnt <= cnt + 1'b1;
    end
  end
`else
  assign is_mul = 1'b0;
  assign state_nxt = IDLE;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      memWeOut <= 1'b0;
      regWeOut <= 1'b0;
      writeRegFromAluOut <= 1'b0;
      regToWriteOut <= '0;
      resultOut <= '0;
      dataToWriteOut <= '0;
      flags <= '0;
      redirect <= 1'b0;
      newPc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      memWeOut <= 1'b0;
      regWeOut <= 1'b0;
      redirect <= 1'b0;
    end
`ifdef EXEC_MUL_EN
    else if (mul_done) begin
      out_valid <= 1'b1;
      memWeOut <= m_mwe;
      regWeOut <= m_rwe;
      writeRegFromAluOut <= m_wrfa;
      regToWriteOut <= m_rd;
      resultOut <= mul_lo;
      dataToWriteOut <= m_data;
      redirect <= m_pwe;
      if (m_pwe) newPc <= mul_lo;
      if (m_fwe) flags <= mul_flags;
    end
`endif
    else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      memWeOut <= memWe;
      regWeOut <= regWe;
      writeRegFromAluOut <= writeRegFromAlu;
      regToWriteOut <= regToWrite;
      resultOut <= alu_res;
      dataToWriteOut <= dataToWrite;
      redirect <= pcWe;
      if (pcWe) newPc <= alu_res;
      if (flagsWe) flags <= alu_flags;
    end else if (!stall) begin
      out_valid <= 1'b0;
      memWeOut <= 1'b0;
      regWeOut <= 1'b0;
      redirect <= 1'b0;
    end
  end
endmodule
